// File: rtl/avg_threshold_detector.sv
`default_nettype none
// ============================================================================
// Module      : avg_threshold_detector
// Description : Hysteresis classifier for a stream of signed averaged samples.
//               A sample is "above" when in_avg > thr_hi and "below" when
//               in_avg < thr_lo; equality never qualifies. HOLD consecutive
//               qualifying valid samples are required before the
//               classification flips. Emits one-cycle rise/fall pulses and a
//               saturating count of rise events.
// Ports       : clk          - clock, all logic on posedge
//               rst          - asynchronous active-high reset
//               in_valid     - sample strobe
//               in_avg       - signed averaged sample [WIDTH]
//               thr_hi       - signed upper threshold [WIDTH]
//               thr_lo       - signed lower threshold [WIDTH]
//               out_valid    - registered copy of in_valid
//               out_above    - 1 = HIGH, 0 = LOW or UNKNOWN
//               rise_pulse   - one-cycle pulse on LOW->HIGH
//               fall_pulse   - one-cycle pulse on HIGH->LOW
//               event_count  - saturating rise-event count [CNT_W]
// Revision    : 1.0 - initial release
// ============================================================================
module avg_threshold_detector #(
   parameter int WIDTH = 32,
   parameter int HOLD  = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_avg,
   input  logic [WIDTH-1:0] thr_hi,
   input  logic [WIDTH-1:0] thr_lo,
   output logic             out_valid,
   output logic             out_above,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] event_count
);

   // Qualification counter is just wide enough to hold the value HOLD.
   localparam int              c_QW   = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
   localparam logic [c_QW-1:0] c_HOLD = c_QW'(HOLD);

   typedef enum logic [1:0] {
      S_UNKNOWN = 2'd0,
      S_LOW     = 2'd1,
      S_HIGH    = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_QW-1:0]   r_qual;
   logic [c_QW-1:0]   w_qual_nxt;
   logic [c_QW-1:0]   w_qual_inc;
   logic              w_above;
   logic              w_below;
   logic              w_rise;
   logic              w_fall;
   logic              r_valid;
   logic              r_rise;
   logic              r_fall;
   logic [CNT_W-1:0]  r_count;

   assign w_above    = $signed(in_avg) > $signed(thr_hi);
   assign w_below    = $signed(in_avg) < $signed(thr_lo);
   // r_qual stays below HOLD between samples, so the increment cannot wrap.
   assign w_qual_inc = r_qual + c_QW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_qual_nxt  = r_qual;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      if (in_valid) begin
         case (r_state)
            S_UNKNOWN: begin
               w_state_nxt = w_above ? S_HIGH : S_LOW;
               w_qual_nxt  = '0;
            end
            S_LOW: begin
               if (!w_above) begin
                  w_qual_nxt = '0;
               end else if (w_qual_inc == c_HOLD) begin
                  w_state_nxt = S_HIGH;
                  w_qual_nxt  = '0;
                  w_rise      = 1'b1;
               end else begin
                  w_qual_nxt = w_qual_inc;
               end
            end
            S_HIGH: begin
               if (!w_below) begin
                  w_qual_nxt = '0;
               end else if (w_qual_inc == c_HOLD) begin
                  w_state_nxt = S_LOW;
                  w_qual_nxt  = '0;
                  w_fall      = 1'b1;
               end else begin
                  w_qual_nxt = w_qual_inc;
               end
            end
            default: begin
               w_state_nxt = S_UNKNOWN;
               w_qual_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_UNKNOWN;
         r_qual  <= '0;
         r_valid <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_qual  <= w_qual_nxt;
         r_valid <= in_valid;
         r_rise  <= w_rise;
         r_fall  <= w_fall;
         // Saturate: a rise at all-ones still pulses but leaves the count.
         if (w_rise && !(&r_count)) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign out_valid   = r_valid;
   assign out_above   = (r_state == S_HIGH);
   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign event_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_avg_threshold_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_avg_threshold_detector
// Description : Self-checking bench for avg_threshold_detector. Two instances
//               share one stimulus stream: instance A (HOLD=2, CNT_W=16) and
//               instance B (HOLD=1, CNT_W=2). Each is compared every cycle
//               against a behavioural model of the hysteresis rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avg_threshold_detector;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_avg;
   logic [31:0] thr_hi;
   logic [31:0] thr_lo;

   logic        a_valid, a_above, a_rise, a_fall;
   logic [15:0] a_count;
   logic        b_valid, b_above, b_rise, b_fall;
   logic [1:0]  b_count;

   int total;
   int bad;

   // Reference model state per instance: 0 = unknown, 1 = low, 2 = high
   int m_state [2];
   int m_run   [2];
   int m_cnt   [2];
   int m_valid [2];
   int m_rise  [2];
   int m_fall  [2];
   int m_hold  [2];
   int m_cmax  [2];

   avg_threshold_detector #(.WIDTH(32), .HOLD(2), .CNT_W(16)) u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_avg      (in_avg),
      .thr_hi      (thr_hi),
      .thr_lo      (thr_lo),
      .out_valid   (a_valid),
      .out_above   (a_above),
      .rise_pulse  (a_rise),
      .fall_pulse  (a_fall),
      .event_count (a_count)
   );

   avg_threshold_detector #(.WIDTH(32), .HOLD(1), .CNT_W(2)) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_avg      (in_avg),
      .thr_hi      (thr_hi),
      .thr_lo      (thr_lo),
      .out_valid   (b_valid),
      .out_above   (b_above),
      .rise_pulse  (b_rise),
      .fall_pulse  (b_fall),
      .event_count (b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_state[i] = 0;
         m_run[i]   = 0;
         m_cnt[i]   = 0;
         m_valid[i] = 0;
         m_rise[i]  = 0;
         m_fall[i]  = 0;
      end
   endtask

   // One accepted sample for instance i, written straight from the rules.
   task automatic model_sample(input int i, input int v, input int hi, input int lo);
      bit up;
      bit dn;
      up = v > hi;
      dn = v < lo;
      m_valid[i] = 1;
      m_rise[i]  = 0;
      m_fall[i]  = 0;
      if (m_state[i] == 0) begin
         m_state[i] = up ? 2 : 1;
         m_run[i]   = 0;
      end else begin
         if ((m_state[i] == 1 && up) || (m_state[i] == 2 && dn))
            m_run[i] = m_run[i] + 1;
         else
            m_run[i] = 0;
         if (m_run[i] == m_hold[i]) begin
            m_run[i] = 0;
            if (m_state[i] == 1) begin
               m_state[i] = 2;
               m_rise[i]  = 1;
               if (m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            end else begin
               m_state[i] = 1;
               m_fall[i]  = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      check("a_valid", int'(a_valid), m_valid[0]);
      check("a_above", int'(a_above), (m_state[0] == 2) ? 1 : 0);
      check("a_rise",  int'(a_rise),  m_rise[0]);
      check("a_fall",  int'(a_fall),  m_fall[0]);
      check("a_count", int'(a_count), m_cnt[0]);
      check("b_valid", int'(b_valid), m_valid[1]);
      check("b_above", int'(b_above), (m_state[1] == 2) ? 1 : 0);
      check("b_rise",  int'(b_rise),  m_rise[1]);
      check("b_fall",  int'(b_fall),  m_fall[1]);
      check("b_count", int'(b_count), m_cnt[1]);
   endtask

   // Advance one clock: update the model with the inputs the DUT sees at the
   // edge, then compare just after the edge.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (in_valid) begin
               model_sample(i, int'($signed(in_avg)), int'($signed(thr_hi)),
                            int'($signed(thr_lo)));
            end else begin
               m_valid[i] = 0;
               m_rise[i]  = 0;
               m_fall[i]  = 0;
            end
         end
      end
      #1;
      check_all();
   endtask

   // One-cycle strobe followed by a gap cycle.
   task automatic sample(input int v);
      in_valid = 1'b1;
      in_avg   = v;
      step();
      in_valid = 1'b0;
      in_avg   = 32'hDEAD_BEEF;
      step();
   endtask

   task automatic sync_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic set_thr(input int hi, input int lo);
      thr_hi = hi;
      thr_lo = lo;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      m_hold[0] = 2;
      m_cmax[0] = 65535;
      m_hold[1] = 1;
      m_cmax[1] = 3;
      model_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_avg   = '0;
      set_thr(5, 3);

      // Reset held for four cycles
      repeat (4) step();
      rst = 1'b0;

      // Async reset mid-cycle while instance A has qual=1
      sample(2);
      sample(6);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1;
      rst = 1'b0;
      sample(6);

      // Init LOW, a 4 breaks the run, rise one cycle after the 7
      sync_reset();
      sample(2);
      sample(6);
      sample(4);
      sample(6);
      sample(7);

      // From HIGH: in-band and equal samples hold, two belows fall
      sample(4);
      sample(3);
      sample(5);
      sample(2);
      sample(1);

      // Signed thresholds
      sync_reset();
      set_thr(-1, -3);
      sample(-5);
      sample(0);
      sample(-1);
      sample(0);
      sample(0);

      // Alternating extremes drive instance B's count into saturation
      sync_reset();
      set_thr(5, 3);
      for (int k = 0; k < 10; k++) sample((k % 2 == 0) ? 0 : 9);

      // Averages of a 4-tap window over 2..8 (floor division)
      sync_reset();
      set_thr(4, 3);
      for (int k = 2; k <= 5; k++) sample(((k) + (k + 1) + (k + 2) + (k + 3)) / 4);

      // Randomised traffic with back-to-back strobes, gaps and rare resets
      sync_reset();
      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 0) begin
            int lo;
            lo = int'($urandom_range(6, 0)) - 3;
            set_thr(lo + int'($urandom_range(3, 0)), lo);
         end
         rst      = ($urandom_range(99, 0) == 0);
         in_valid = ($urandom_range(3, 0) != 0);
         in_avg   = int'($urandom_range(16, 0)) - 8;
         step();
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
